axi_wr_scheduler: RTL and testbench

AXI_WR_SCHEDULER -- requirements
Module: axi_wr_scheduler

---
 rtl/axi_wr_scheduler.sv | 170 +++++++++++++++++
 tb/tb_axi_wr_scheduler.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_scheduler.sv
// Round-robin write-burst scheduler for two FIFO requesters feeding one AXI master.
// Issues one burst command at a time and tracks per-requester address offsets, counters and errors.
module axi_wr_scheduler #(
    parameter int unsigned DATA_WIDTH   = 256,
    parameter int unsigned BURST_LEN    = 16,
    parameter logic [31:0] REGION0_BASE = 32'h0000_0000,
    parameter logic [31:0] REGION1_BASE = 32'h0010_0000,
    parameter int unsigned REGION_SIZE  = 4096,
    parameter int unsigned TIMEOUT      = 1024
) (
    input  logic        i_axi_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    input  logic [1:0]  i_req,
    output logic        o_cmd_valid,
    input  logic        i_cmd_ready,
    output logic [31:0] o_cmd_addr,
    output logic [1:0]  o_grant,
    input  logic        i_done,
    input  logic [1:0]  i_bresp,
    output logic        o_busy,
    output logic [1:0]  o_err,
    output logic        o_timeout,
    output logic [1:0]  o_wrap,
    output logic [15:0] o_burst_cnt0,
    output logic [15:0] o_burst_cnt1,
    output logic [1:0]  o_state
);

    localparam int unsigned BURST_BYTES = BURST_LEN * (DATA_WIDTH / 8);
    localparam int unsigned TMO_W       = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic [31:0]        cmd_addr_q, cmd_addr_d;
    logic [1:0]         grant_q, grant_d;
    logic               busy_q, busy_d;
    logic [1:0]         err_q, err_d;
    logic               timeout_q, timeout_d;
    logic [1:0]         wrap_q, wrap_d;
    logic [15:0]        cnt0_q, cnt0_d;
    logic [15:0]        cnt1_q, cnt1_d;
    logic [31:0]        off0_q, off0_d;
    logic [31:0]        off1_q, off1_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               rr_q, rr_d;

    logic               win;
    logic [31:0]        off_next;
    logic               wrap_hit;

    always_comb begin
        state_d     = state_q;
        cmd_valid_d = cmd_valid_q;
        cmd_addr_d  = cmd_addr_q;
        grant_d     = grant_q;
        err_d       = err_q;
        timeout_d   = timeout_q;
        wrap_d      = '0;
        cnt0_d      = cnt0_q;
        cnt1_d      = cnt1_q;
        off0_d      = off0_q;
        off1_d      = off1_q;
        tmo_d       = tmo_q;
        rr_d        = rr_q;
        // On a tie the requester that was not granted last wins.
        win         = (i_req == 2'b11) ? ~rr_q : i_req[1];
        off_next    = (grant_q[1] ? off1_q : off0_q) + BURST_BYTES;
        wrap_hit    = (off_next == REGION_SIZE);

        case (state_q)
            IDLE: begin
                if (i_enable && (i_req != '0)) begin
                    grant_d     = win ? 2'b10 : 2'b01;
                    cmd_addr_d  = win ? (REGION1_BASE + off1_q) : (REGION0_BASE + off0_q);
                    cmd_valid_d = 1'b1;
                    rr_d        = win;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (i_cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    tmo_d       = '0;
                    state_d     = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (i_done) begin
                    if (grant_q[1]) begin
                        cnt1_d    = cnt1_q + 16'd1;
                        err_d[1]  = err_q[1] | (i_bresp != 2'b00);
                        off1_d    = wrap_hit ? '0 : off_next;
                        wrap_d[1] = wrap_hit;
                    end else begin
                        cnt0_d    = cnt0_q + 16'd1;
                        err_d[0]  = err_q[0] | (i_bresp != 2'b00);
                        off0_d    = wrap_hit ? '0 : off_next;
                        wrap_d[0] = wrap_hit;
                    end
                    grant_d = '0;
                    state_d = IDLE;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    grant_d   = '0;
                    state_d   = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_axi_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            cmd_valid_q <= 1'b0;
            cmd_addr_q  <= REGION0_BASE;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            err_q       <= '0;
            timeout_q   <= 1'b0;
            wrap_q      <= '0;
            cnt0_q      <= '0;
            cnt1_q      <= '0;
            off0_q      <= '0;
            off1_q      <= '0;
            tmo_q       <= '0;
            rr_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_addr_q  <= cmd_addr_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            timeout_q   <= timeout_d;
            wrap_q      <= wrap_d;
            cnt0_q      <= cnt0_d;
            cnt1_q      <= cnt1_d;
            off0_q      <= off0_d;
            off1_q      <= off1_d;
            tmo_q       <= tmo_d;
            rr_q        <= rr_d;
        end
    end

    assign o_cmd_valid  = cmd_valid_q;
    assign o_cmd_addr   = cmd_addr_q;
    assign o_grant      = grant_q;
    assign o_busy       = busy_q;
    assign o_err        = err_q;
    assign o_timeout    = timeout_q;
    assign o_wrap       = wrap_q;
    assign o_burst_cnt0 = cnt0_q;
    assign o_burst_cnt1 = cnt1_q;
    assign o_state      = state_q;

endmodule

// File: tb/tb_axi_wr_scheduler.sv
// Scoreboard bench for axi_wr_scheduler: the driver queues expected commands,
// a negedge monitor pops and compares them as the DUT raises o_cmd_valid.
module tb_axi_wr_scheduler;

    logic        i_axi_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_enable = 1'b1;
    logic [1:0]  i_req = '0;
    logic        o_cmd_valid;
    logic        i_cmd_ready = 1'b0;
    logic [31:0] o_cmd_addr;
    logic [1:0]  o_grant;
    logic        i_done = 1'b0;
    logic [1:0]  i_bresp = '0;
    logic        o_busy;
    logic [1:0]  o_err;
    logic        o_timeout;
    logic [1:0]  o_wrap;
    logic [15:0] o_burst_cnt0;
    logic [15:0] o_burst_cnt1;
    logic [1:0]  o_state;

    axi_wr_scheduler dut (
        .i_axi_clk    (i_axi_clk),
        .i_rst        (i_rst),
        .i_enable     (i_enable),
        .i_req        (i_req),
        .o_cmd_valid  (o_cmd_valid),
        .i_cmd_ready  (i_cmd_ready),
        .o_cmd_addr   (o_cmd_addr),
        .o_grant      (o_grant),
        .i_done       (i_done),
        .i_bresp      (i_bresp),
        .o_busy       (o_busy),
        .o_err        (o_err),
        .o_timeout    (o_timeout),
        .o_wrap       (o_wrap),
        .o_burst_cnt0 (o_burst_cnt0),
        .o_burst_cnt1 (o_burst_cnt1),
        .o_state      (o_state)
    );

    always #5 i_axi_clk = ~i_axi_clk;

    typedef struct packed {
        logic [1:0]  grant;
        logic [31:0] addr;
    } cmd_t;

    cmd_t exp_q[$];
    cmd_t cur = '0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   wrap0_hi = 0;
    int   wrap1_hi = 0;
    logic prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops an expected command on each rising o_cmd_valid, then watches stability.
    always @(negedge i_axi_clk) begin
        if (o_wrap[0]) wrap0_hi++;
        if (o_wrap[1]) wrap1_hi++;
        if (o_cmd_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL cmd_unexpected: got addr 0x%0h grant %b, expected no command", o_cmd_addr, o_grant);
            end else begin
                cur = exp_q.pop_front();
                check("cmd_grant", 32'(o_grant), 32'(cur.grant));
                check("cmd_addr", o_cmd_addr, cur.addr);
            end
        end else if (o_cmd_valid) begin
            check("issue_addr_stable", o_cmd_addr, cur.addr);
            check("issue_grant_stable", 32'(o_grant), 32'(cur.grant));
        end else if (o_state == 2'd2) begin
            check("wait_grant_hold", 32'(o_grant), 32'(cur.grant));
        end
        prev_valid = o_cmd_valid;
    end

    task automatic clk1();
        @(posedge i_axi_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        i_req = '0;
        i_done = 1'b0;
        i_cmd_ready = 1'b0;
        clk1();
        clk1();
        i_rst = 1'b0;
        check("rst_state", 32'(o_state), 32'd0);
        check("rst_valid", 32'(o_cmd_valid), 32'd0);
        check("rst_grant", 32'(o_grant), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_wrap", 32'(o_wrap), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        check("rst_timeout", 32'(o_timeout), 32'd0);
        check("rst_cnt0", 32'(o_burst_cnt0), 32'd0);
        check("rst_cnt1", 32'(o_burst_cnt1), 32'd0);
        check("rst_addr", o_cmd_addr, 32'h0);
    endtask

    // mode: 0 = done after accept, 1 = no done (expect timeout), 2 = reset in WAIT_DONE
    task automatic burst(input logic [1:0] req, input logic [1:0] exp_grant,
                         input logic [31:0] exp_addr, input int rdy_dly,
                         input logic [1:0] bresp, input int mode);
        int k;
        exp_q.push_back('{grant: exp_grant, addr: exp_addr});
        i_req = req;
        k = 0;
        while (!o_cmd_valid && k < 10) begin
            clk1();
            k++;
        end
        if (!o_cmd_valid) begin
            check("cmd_valid_arrival", 32'(o_cmd_valid), 32'd1);
            i_req = '0;
            return;
        end
        i_req = '0;
        for (int d = 0; d < rdy_dly; d++) begin
            i_done = (d == 0);  // stray done while in ISSUE must be ignored
            clk1();
            i_done = 1'b0;
        end
        i_cmd_ready = 1'b1;
        clk1();
        i_cmd_ready = 1'b0;
        i_enable = 1'b0;
        check("accept_valid_low", 32'(o_cmd_valid), 32'd0);
        check("accept_state", 32'(o_state), 32'd2);
        if (mode == 0) begin
            clk1();
            clk1();
            i_done = 1'b1;
            i_bresp = bresp;
            clk1();
            i_done = 1'b0;
            i_bresp = '0;
            check("done_state", 32'(o_state), 32'd0);
            check("done_grant", 32'(o_grant), 32'd0);
        end else if (mode == 1) begin
            k = 0;
            while (o_busy && k < 1100) begin
                clk1();
                k++;
            end
            check("timeout_cycles", 32'(k), 32'd1024);
        end else begin
            clk1();
            i_rst = 1'b1;
            clk1();
            i_rst = 1'b0;
            i_done = 1'b1;
            clk1();
            i_done = 1'b0;
        end
        i_enable = 1'b1;
    endtask

    int w0;

    initial begin
        // Single burst on requester 0
        do_reset();
        burst(2'b01, 2'b01, 32'h0, 3, 2'b00, 0);
        check("single_cnt0", 32'(o_burst_cnt0), 32'd1);
        check("single_cnt1", 32'(o_burst_cnt1), 32'd0);
        burst(2'b01, 2'b01, 32'h200, 0, 2'b00, 0);
        check("single_cnt0_b", 32'(o_burst_cnt0), 32'd2);

        // Tie, two rounds
        do_reset();
        burst(2'b11, 2'b01, 32'h0000_0000, 1, 2'b00, 0);
        burst(2'b11, 2'b10, 32'h0010_0000, 0, 2'b00, 0);
        burst(2'b11, 2'b01, 32'h0000_0200, 2, 2'b00, 0);
        burst(2'b11, 2'b10, 32'h0010_0200, 0, 2'b00, 0);
        check("tie_cnt0", 32'(o_burst_cnt0), 32'd2);
        check("tie_cnt1", 32'(o_burst_cnt1), 32'd2);

        // Wrap on requester 0
        do_reset();
        w0 = wrap0_hi;
        for (int i = 0; i < 8; i++) begin
            burst(2'b01, 2'b01, 32'(i) * 32'h200, 0, 2'b00, 0);
            if (i == 6) check("wrap_not_yet", 32'(wrap0_hi - w0), 32'd0);
        end
        clk1();
        check("wrap0_pulses", 32'(wrap0_hi - w0), 32'd1);
        check("wrap_live_low", 32'(o_wrap), 32'd0);
        burst(2'b01, 2'b01, 32'h0, 0, 2'b00, 0);
        check("wrap_cnt0", 32'(o_burst_cnt0), 32'd9);

        // Error response on requester 1
        do_reset();
        burst(2'b10, 2'b10, 32'h0010_0000, 1, 2'b10, 0);
        check("err_flag", 32'(o_err), 32'h2);
        check("err_cnt1", 32'(o_burst_cnt1), 32'd1);
        burst(2'b10, 2'b10, 32'h0010_0200, 0, 2'b00, 0);
        check("err_sticky", 32'(o_err), 32'h2);
        check("err_wrap1", 32'(wrap1_hi), 32'd0);

        // Done timeout
        do_reset();
        burst(2'b01, 2'b01, 32'h0, 2, 2'b00, 1);
        check("tmo_flag", 32'(o_timeout), 32'd1);
        check("tmo_grant", 32'(o_grant), 32'd0);
        check("tmo_state", 32'(o_state), 32'd0);
        check("tmo_cnt0", 32'(o_burst_cnt0), 32'd0);
        burst(2'b01, 2'b01, 32'h0, 0, 2'b00, 0);
        check("tmo_sticky", 32'(o_timeout), 32'd1);
        check("tmo_cnt0_after", 32'(o_burst_cnt0), 32'd1);

        // Reset in WAIT_DONE followed by a late done pulse
        do_reset();
        burst(2'b01, 2'b01, 32'h0, 0, 2'b00, 0);
        burst(2'b01, 2'b01, 32'h200, 1, 2'b00, 2);
        clk1();
        check("mid_rst_state", 32'(o_state), 32'd0);
        check("mid_rst_busy", 32'(o_busy), 32'd0);
        check("mid_rst_grant", 32'(o_grant), 32'd0);
        check("mid_rst_cnt0", 32'(o_burst_cnt0), 32'd0);
        check("mid_rst_addr", o_cmd_addr, 32'h0);
        burst(2'b01, 2'b01, 32'h0, 0, 2'b00, 0);

        clk1();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
